// File: rtl/pipeline_wb_regs.sv
// Write-back register chain (MEM -> regfile) with stall, flush, x0 suppression and
// per-port forwarding lookup. Define WB_PERF_CNT_EN to add retire/stall counters.
module pipeline_wb_regs #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 1,
  parameter int NUM_RS = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       stall_i,
  input  logic                       flush_i,
  input  logic                       rd_wren_i,
  input  logic [ADDR_W-1:0]          rd_addr_i,
  input  logic [DATA_W-1:0]          wb_data_i,
  input  logic [NUM_RS*ADDR_W-1:0]   rs_addr_i,
  output logic                       rd_wren_o,
  output logic [ADDR_W-1:0]          rd_addr_o,
  output logic [DATA_W-1:0]          wb_data_o,
  output logic [NUM_RS-1:0]          fwd_hit_o,
  output logic [NUM_RS*DATA_W-1:0]   fwd_data_o
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]                retire_cnt_o,
  output logic [31:0]                stall_cnt_o
`endif
);

  logic [DEPTH-1:0]  wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  // Slot update: flush beats stall; a stalled input is dropped, upstream holds it
  always_comb begin
    wren_d = wren_q;
    addr_d = addr_q;
    data_d = data_q;
    if (flush_i) begin
      wren_d = '0;
      for (int k = 0; k < DEPTH; k++) begin
        addr_d[k] = '0;
        data_d[k] = '0;
      end
    end else if (!stall_i) begin
      wren_d[0] = rd_wren_i && (rd_addr_i != '0);
      addr_d[0] = rd_addr_i;
      data_d[0] = wb_data_i;
      for (int k = 1; k < DEPTH; k++) begin
        wren_d[k] = wren_q[k-1];
        addr_d[k] = addr_q[k-1];
        data_d[k] = data_q[k-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wren_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        addr_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      wren_q <= wren_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign rd_wren_o = wren_q[DEPTH-1];
  assign rd_addr_o = addr_q[DEPTH-1];
  assign wb_data_o = data_q[DEPTH-1];

  // Oldest-to-youngest scan so the lowest matching slot wins
  always_comb begin
    logic [ADDR_W-1:0] rs;
    fwd_hit_o  = '0;
    fwd_data_o = '0;
    rs         = '0;
    for (int j = 0; j < NUM_RS; j++) begin
      rs = rs_addr_i[j*ADDR_W +: ADDR_W];
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (wren_q[k] && (addr_q[k] == rs) && (rs != '0)) begin
          fwd_hit_o[j]                      = 1'b1;
          fwd_data_o[j*DATA_W +: DATA_W]    = data_q[k];
        end
      end
    end
  end

`ifdef WB_PERF_CNT_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (!flush_i && !stall_i && wren_q[DEPTH-1] && (retire_cnt_q != 32'hFFFF_FFFF))
      retire_cnt_d = retire_cnt_q + 32'd1;
    if (!flush_i && stall_i && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign retire_cnt_o = retire_cnt_q;
  assign stall_cnt_o  = stall_cnt_q;
`endif

endmodule
